// File: rtl/logarithm_pkg.sv
// logarithm_pkg: shared constants and FSM state type for the fixed-point natural log block.
package logarithm_pkg;
  localparam int SCALE_DEF = 1000;
  localparam int TERMS_DEF = 20;
  localparam int E_FIXED = 2718;
  localparam int INV_E_FIXED = 368;
  localparam logic [31:0] RESULT_ERR = 32'h8000_0000;
  typedef enum logic [2:0] {IDLE, REDUCE, SETUP, SERIES, DONE} state_t;
endpackage

// File: rtl/logarithm.sv
// logarithm: sequential fixed-point ln(x) via reduction by e and an atanh series.
// Optional macro LOGARITHM_EARLY_EXIT_EN ends SERIES once a term contributes nothing.
module logarithm
  import logarithm_pkg::*;
#(
  parameter int SCALE = SCALE_DEF,
  parameter int TERMS = TERMS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        x_in,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] result,
  output logic               error
);
  localparam logic signed [63:0] S = 64'(SCALE);
  localparam logic signed [63:0] E = 64'(E_FIXED);
  localparam logic signed [63:0] I = 64'(INV_E_FIXED);
  state_t state;
  logic signed [63:0] m, k, u, u2, term, sum, n;
  logic signed [63:0] mul_a, mul_b, div_d, quo, cur, contrib, sum_next;
  logic up, last;
  // one shared multiply-divide serves reduction, u setup and term update
  assign up = m >= E;
  assign cur = (n == 0) ? u : term;
  assign mul_a = state == REDUCE ? m : state == SETUP ? m - S : cur;
  assign mul_b = state == REDUCE ? (up ? S : E) : state == SETUP ? S : u2;
  assign div_d = state == REDUCE ? (up ? E : S) : state == SETUP ? m + S : S;
  assign quo = (mul_a * mul_b) / div_d;
  assign contrib = cur / (2 * n + 1);
  assign sum_next = sum + contrib;
  assign busy = state != IDLE;
`ifdef LOGARITHM_EARLY_EXIT_EN
  assign last = n == 64'(TERMS - 1) || contrib == 0;
`else
  assign last = n == 64'(TERMS - 1);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      result <= '0;
      error <= 1'b0;
      m <= '0;
      k <= '0;
      u <= '0;
      u2 <= '0;
      term <= '0;
      sum <= '0;
      n <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (x_in == 32'd0) begin
            result <= RESULT_ERR;
            error <= 1'b1;
            state <= DONE;
          end else begin
            m <= {32'd0, x_in};
            k <= '0;
            state <= REDUCE;
          end
        end
        REDUCE: if (up || m < I) begin
          m <= quo;
          k <= up ? k + 1 : k - 1;
        end else state <= SETUP;
        SETUP: begin
          u <= quo;
          u2 <= quo * quo / S;
          term <= quo;
          sum <= '0;
          n <= '0;
          state <= SERIES;
        end
        SERIES: begin
          sum <= sum_next;
          term <= quo;
          n <= n + 1;
          if (last) begin
            result <= 32'(k * S + 2 * sum_next);
            error <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // error path arrives with done low and pulses it one cycle later
          done <= !done;
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logarithm.sv
// tb_logarithm: randomized and directed checks of logarithm against an arithmetic reference model.
module tb_logarithm;
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] x_in = 0;
  logic busy, done, error;
  logic signed [31:0] result;
  int errors = 0, checks = 0;

  logarithm dut (.clk(clk), .rst(rst), .start(start), .x_in(x_in), .busy(busy),
                 .done(done), .result(result), .error(error));

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input longint x, output int res, output bit err, output int lat);
    longint m = x, k = 0, u, u2, t, s = 0, c;
    int r = 0, nc = 0;
    if (x == 0) begin
      res = 32'h8000_0000; err = 1; lat = 1;
      return;
    end
    while (m >= 2718 || m < 368) begin
      if (m >= 2718) begin m = m * 1000 / 2718; k++; end
      else begin m = m * 2718 / 1000; k--; end
      r++;
    end
    u = ((m - 1000) * 1000) / (m + 1000);
    u2 = u * u / 1000;
    t = u;
    for (int i = 0; i < 20; i++) begin
      c = t / (2 * i + 1);
      s += c;
      t = t * u2 / 1000;
      nc++;
`ifdef LOGARITHM_EARLY_EXIT_EN
      if (c == 0) break;
`endif
    end
    res = int'(k * 1000 + 2 * s);
    err = 0;
    lat = r + nc + 2;
  endfunction

  task automatic run(input logic [31:0] x, input bit hold, output int lat,
                     output logic signed [31:0] r, output logic e);
    @(negedge clk);
    x_in = x;
    start = 1;
    @(posedge clk);
    #1;
    if (!hold) start = 0;
    x_in = $urandom;
    check("busy_after_start", busy, 1);
    lat = 0;
    while (!done && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    start = 0;
    r = result;
    e = error;
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
  endtask

  task automatic test(input string tag, input logic [31:0] x, input bit hold, input bit fixed,
                      input int fres);
    int lat, mres, mlat;
    bit merr;
    logic signed [31:0] r;
    logic e;
    model(longint'(x), mres, merr, mlat);
    run(x, hold, lat, r, e);
    check({tag, "_result"}, r, fixed ? fres : mres);
    check({tag, "_error"}, e, merr);
    check({tag, "_latency"}, lat, mlat);
    if (hold) begin
      repeat (4) begin
        @(posedge clk);
        #1;
        check({tag, "_no_second_done"}, done, 0);
      end
      check({tag, "_result_held"}, result, r);
    end
  endtask

  initial begin
    int lat;
    logic signed [31:0] r;
    logic e;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_error", error, 0);
    @(negedge clk);
    rst = 0;
    test("unity", 1000, 0, 1, 0);
`ifndef LOGARITHM_EARLY_EXIT_EN
    run(1000, 0, lat, r, e);
    check("unity_lat22", lat, 22);
    run(2718, 0, lat, r, e);
    check("e_lat23", lat, 23);
    run(20085, 0, lat, r, e);
    check("e3_lat25", lat, 25);
    run(500, 0, lat, r, e);
    check("half_lat22", lat, 22);
`else
    run(500, 0, lat, r, e);
    check("half_lat5", lat, 5);
`endif
    test("e", 2718, 0, 1, 1000);
    test("e_cubed", 20085, 1, 1, 3000);
    test("half", 500, 0, 1, -690);
    test("zero", 0, 1, 1, 32'h8000_0000);
    test("one", 1, 0, 0, 0);
    test("max", 32'hFFFF_FFFF, 0, 0, 0);
    test("lo_edge", 368, 0, 0, 0);
    test("below_lo", 367, 0, 0, 0);
    test("hi_edge", 2717, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      logic [31:0] x;
      case (i % 3)
        0: x = $urandom_range(1, 400);
        1: x = $urandom_range(300, 5000);
        default: x = $urandom;
      endcase
      test("rand", x, i[0], 0, 0);
    end
    test("pre_reset", 2718, 0, 1, 1000);
    @(negedge clk);
    x_in = 1000;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_error", error, 0);
    @(negedge clk);
    rst = 0;
    test("post_reset", 1000, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logarithm.md
LOGARITHM -- requirements
Module: logarithm

Interface
REQ-001 SHALL have parameter SCALE, default 1000, meaning fixed-point unity (1.0 = 1000).
REQ-002 SHALL have parameter TERMS, default 20, meaning the maximum number of atanh-series terms.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-006 SHALL have port x_in, input, 32 bits unsigned: operand, fixed-point at SCALE; captured on the accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-009 SHALL have port result, output, 32 bits signed: ln(x_in), fixed-point at SCALE.
REQ-010 SHALL have port error, output, 1 bit: x_in was 0; valid with done.

Function
REQ-011 SHALL implement the states IDLE, REDUCE, SETUP, SERIES and DONE.
REQ-012 IDLE with start=1: SHALL capture m=x_in, set k=0 and go to REDUCE; x_in=0 SHALL instead go straight to DONE with error=1 and result=32'h8000_0000.
REQ-013 REDUCE, one action per cycle:
- if m>=2718: m=m*1000/2718 and k++;
- else if m<368: m=m*2718/1000 and k--;
- else go to SETUP.
REQ-014 SETUP, in one cycle:
- u=((m-SCALE)*SCALE)/(m+SCALE);
- u2=u*u/SCALE;
- term=u, sum=0, n=0;
- go to SERIES.
REQ-015 SERIES, one term per cycle:
- sum+=term/(2n+1);
- term=term*u2/SCALE;
- n++;
- after TERMS cycles, go to DONE.
REQ-016 DONE SHALL:
- set result=k*SCALE+2*sum;
- set error=0 (except the REQ-012 case);
- assert done for exactly one cycle;
- return to IDLE.
REQ-017 Arithmetic SHALL use 64-bit signed intermediates, with division truncating toward zero.
REQ-018 result and error SHALL hold until the next DONE.
REQ-019 start outside IDLE (including in the DONE cycle) SHALL be ignored; x_in changes after capture SHALL have no effect.
REQ-020 Latency SHALL be R+N+2 rising edges from the start-sampling edge to done high, where R is the reduction count and N is the number of SERIES cycles; for x_in=0, done SHALL be high one edge after the start-sampling edge.

Reset
REQ-021 rst SHALL immediately force IDLE, busy=0, done=0, result=0, error=0, and clear the internal m, k, u, u2, term, sum and n, including mid-operation.
REQ-022 After rst deasserts, the first accepted start SHALL behave as from power-up; no partial result SHALL ever be signalled.

Configuration
REQ-023 Macro LOGARITHM_EARLY_EXIT_EN defined: the SERIES cycle whose contribution term/(2n+1) equals 0 SHALL be the last one, then DONE; the TERMS limit still applies.
REQ-024 Macro LOGARITHM_EARLY_EXIT_EN undefined: SERIES SHALL always run exactly TERMS cycles; result values SHALL be identical in both builds.

Structure
REQ-025 Package logarithm_pkg SHALL hold:
- SCALE_DEF=1000;
- TERMS_DEF=20;
- E_FIXED=2718;
- INV_E_FIXED=368;
- RESULT_ERR=32'h8000_0000;
- the state enum typedef.
REQ-026 The block SHALL be a single module with no sub-module; the multiply/divide datapath stays inline and is shared across states.

Verification
REQ-027 Case x_in=1000, no macro -> result=0, error=0, done 22 edges after start.
REQ-028 Case x_in=2718 -> one reduction, result=1000, done after 23 edges (no macro).
REQ-029 Case x_in=20085 -> three reductions (7389, 2718, 1000), result=3000, done after 25 edges (no macro).
REQ-030 Case x_in=500 -> u=-333, u2=110, result=-690. With LOGARITHM_EARLY_EXIT_EN: done after 5 edges. Without: done after 22 edges.
REQ-031 Case x_in=0 -> error=1, result=32'h8000_0000, done one edge after start. A start pulse held while busy=1 -> ignored, with no second done.
REQ-032 Case rst asserted during SERIES, then x_in=1000 started -> IDLE immediately with outputs 0, then a clean result of 0.
